// File: rtl/spu_if_pkg.sv
// Shared definitions for the instruction-fetch buffer writer.
//   LINE_LENGTH    : instruction buffer depth in words
//   ADDR_W         : buffer word address width
//   INSTR_W        : packed instruction width in bits
//   loader_state_t : loader FSM state encoding
package spu_if_pkg;

  localparam int LINE_LENGTH = 1024;
  localparam int ADDR_W      = $clog2(LINE_LENGTH);
  localparam int INSTR_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: assembles accepted program bytes into big-endian 32-bit words.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : drops any partial word and rewinds to lane 0
//   accept      : in_byte / in_last are taken this cycle
//   in_byte     : program byte, bit 0 is the MSB
//   in_last     : closes the current word early, unfilled lanes read as zero
//   last_lane   : the next accepted byte fills lane 3 and completes the word
//   word        : completed instruction, lane 0 in bits [0:7]
//   word_valid  : one-cycle strobe, registered, the cycle after completion
module byte_packer
  import spu_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [0:7]         in_byte,
  input  logic               in_last,
  output logic               last_lane,
  output logic [0:INSTR_W-1] word,
  output logic               word_valid
);

  logic [1:0]         lane;
  logic [0:INSTR_W-1] acc;
  logic [0:INSTR_W-1] merged;

  assign last_lane = (lane == 2'd3);

  // Unfilled lanes of acc are always zero, so OR-ing the shifted byte in
  // both fills the current lane and leaves the zero padding in place.
  always_comb begin
    merged = acc | ({in_byte, 24'h000000} >> {lane, 3'b000});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= 2'd0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
        acc  <= '0;
      end else if (accept) begin
        if (last_lane || in_last) begin
          word       <= merged;
          word_valid <= 1'b1;
          acc        <= '0;
          lane       <= 2'd0;
        end else begin
          acc  <= merged;
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: writer side of the instruction-fetch buffer.
// Packs a byte-serial program stream into 32-bit words and writes them
// sequentially from address 0, tracking length, completion and overflow.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a new load (honoured in IDLE or DONE)
//   in_valid/in_byte/in_last, in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data : buffer write port, one-cycle strobe
//   busy          : loading in progress
//   load_done     : level, program fully written
//   overflow_err  : sticky, buffer filled without in_last
//   instr_count   : words written, 0..LINE_LENGTH
module instr_loader #(
  parameter int LINE_LENGTH = spu_if_pkg::LINE_LENGTH,
  parameter int ADDR_W      = spu_if_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [0:7]      in_byte,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [0:ADDR_W-1] wr_addr,
  output logic [0:31]     wr_data,
  output logic            busy,
  output logic            load_done,
  output logic            overflow_err,
  output logic [0:ADDR_W] instr_count
);

  import spu_if_pkg::*;

  loader_state_t state, next_state;
  logic          accept;
  logic          clear;
  logic          finish;
  logic          last_lane;
  logic          word_valid;
  logic [0:31]   word;
  logic          ovf_pend;

  assign accept = in_valid && in_ready;

  // The count only trails by the single in-flight write, so when the final
  // buffer word is being packed the count already equals LINE_LENGTH-1.
  assign finish = accept &&
                  (in_last || (last_lane && (instr_count == (ADDR_W+1)'(LINE_LENGTH - 1))));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .last_lane  (last_lane),
    .word       (word),
    .word_valid (word_valid)
  );

  assign wr_en   = word_valid;
  assign wr_data = word;
  assign wr_addr = instr_count[1:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (finish) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The final word is written in the first DONE cycle, so the flags are
  // raised from that write and appear together with the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count  <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      ovf_pend     <= 1'b0;
    end else if (clear) begin
      instr_count  <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      ovf_pend     <= 1'b0;
    end else begin
      if (word_valid) instr_count <= instr_count + (ADDR_W+1)'(1);
      if (finish)     ovf_pend    <= !in_last;
      if ((state == DONE) && word_valid) begin
        load_done    <= 1'b1;
        overflow_err <= ovf_pend;
      end
    end
  end

endmodule
